// File: rtl/mpu_stream_transpose.sv
// mpu_stream_transpose
//   Streams in an N x N matrix of W-bit elements one row per transfer, then
//   streams it back out one row per transfer. The output is either the transpose
//   (output row k = input column k) or the original rows, selected per matrix by
//   the mode sampled with the first input row. Load and drain phases do not overlap.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       asynchronous active-low reset
//   abort_i      synchronous abort, discards the matrix in progress
//   mode_i       0 = transpose, 1 = pass-through (sampled with row 0)
//   in_valid_i   in_row_i carries a valid row
//   in_ready_o   block accepts a row this cycle
//   in_row_i     input row, element c at [W*c +: W]
//   out_valid_o  out_row_o carries a valid row
//   out_ready_i  downstream accepts out_row_o this cycle
//   out_row_o    output row, element c at [W*c +: W]
//   out_last_o   high with the final output row of a matrix
//   busy_o       high while a matrix is partially loaded or draining

module mpu_stream_transpose #(
    parameter int unsigned N = 5,
    parameter int unsigned W = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           abort_i,
    input  logic           mode_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [N*W-1:0] in_row_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [N*W-1:0] out_row_o,
    output logic           out_last_o,
    output logic           busy_o
);

    localparam int unsigned    CntW   = $clog2(N);
    localparam logic [CntW-1:0] CntMax = CntW'(N - 1);

    typedef enum logic {
        StLoad,
        StDrain
    } state_e;

    state_e                     state_q, state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic                       mode_q, mode_d;
    // mem_q[row][col]; a packed row lines up with the in_row_i element layout
    logic [N-1:0][N-1:0][W-1:0] mem_q, mem_d;

    logic in_xfer;
    logic out_xfer;
    logic cnt_last;

    // All handshake outputs come straight from registered state.
    assign in_ready_o  = (state_q == StLoad);
    assign out_valid_o = (state_q == StDrain);
    assign cnt_last    = (cnt_q == CntMax);
    assign out_last_o  = out_valid_o && cnt_last;
    assign busy_o      = (state_q == StDrain) || (cnt_q != '0);
    assign in_xfer     = in_valid_i && in_ready_o;
    assign out_xfer    = out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        mem_d   = mem_q;

        if (abort_i) begin
            // Abort beats any transfer in the same cycle.
            state_d = StLoad;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (in_xfer) begin
                        mem_d[cnt_q] = in_row_i;
                        if (cnt_q == '0) begin
                            mode_d = mode_i;
                        end
                        if (cnt_last) begin
                            cnt_d   = '0;
                            state_d = StDrain;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (out_xfer) begin
                        if (cnt_last) begin
                            cnt_d   = '0;
                            state_d = StLoad;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StLoad;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            mem_q   <= mem_d;
        end
    end

    // cnt_q selects the output row: a column of mem_q when transposing, a row otherwise.
    always_comb begin
        out_row_o = '0;
        for (int c = 0; c < N; c++) begin
            out_row_o[W*c +: W] = mode_q ? mem_q[cnt_q][c] : mem_q[c][cnt_q];
        end
    end

endmodule

// File: tb/tb_mpu_stream_transpose.sv
// Self-checking bench for mpu_stream_transpose (N=5, W=8). A reference matrix
// and its mode are kept here; expected output rows are computed directly from
// the matrix as either column k or row k.

module tb_mpu_stream_transpose;

    localparam int N  = 5;
    localparam int W  = 8;
    localparam int RW = N * W;

    logic          clk;
    logic          rst_n;
    logic          abort;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] in_row;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_row;
    logic          out_last;
    logic          busy;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] mat [N][N];
    logic         mode_ref;

    mpu_stream_transpose #(
        .N(N),
        .W(W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .abort_i    (abort),
        .mode_i     (mode),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_row_i   (in_row),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_row_o  (out_row),
        .out_last_o (out_last),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] pack_row(input int r);
        logic [RW-1:0] v;
        for (int c = 0; c < N; c++) v[W*c +: W] = mat[r][c];
        return v;
    endfunction

    // Output row k: column k of the input when transposing, row k otherwise.
    function automatic logic [RW-1:0] exp_row(input int k);
        logic [RW-1:0] v;
        for (int c = 0; c < N; c++) v[W*c +: W] = mode_ref ? mat[k][c] : mat[c][k];
        return v;
    endfunction

    task automatic fill_pattern();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mat[r][c] = W'(10 * r + c);
    endtask

    task automatic fill_random();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mat[r][c] = W'($urandom());
    endtask

    // Feeds the first `rows` rows of mat; mode is inverted after row 0 to show it is ignored.
    task automatic load(input string tag, input bit m, input bit gaps, input int rows);
        for (int r = 0; r < rows; r++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    mode     = 1'($urandom_range(0, 1));
                    in_row   = RW'({$urandom(), $urandom()});
                    check({tag, ":gap_busy"}, 64'(busy), 64'(r != 0));
                    check({tag, ":gap_ready"}, 64'(in_ready), 64'd1);
                    step();
                end
            end
            in_valid = 1'b1;
            in_row   = pack_row(r);
            mode     = (r == 0) ? m : ~m;
            check({tag, ":ld_ready"}, 64'(in_ready), 64'd1);
            check({tag, ":ld_ovalid"}, 64'(out_valid), 64'd0);
            step();
        end
        in_valid = 1'b0;
        mode_ref = m;
        if (rows == N) check({tag, ":latency"}, 64'(out_valid), 64'd1);
    endtask

    task automatic drain(input string tag, input bit rand_ready, input int exp_cycles);
        int k   = 0;
        int cyc = 0;
        while (k < N && cyc < 200) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = 1'($urandom_range(0, 1));
            in_row    = RW'({$urandom(), $urandom()});
            mode      = 1'($urandom_range(0, 1));
            check({tag, ":ovalid"}, 64'(out_valid), 64'd1);
            check({tag, ":iready"}, 64'(in_ready), 64'd0);
            check({tag, ":busy"}, 64'(busy), 64'd1);
            check($sformatf("%s:row%0d", tag, k), 64'(out_row), 64'(exp_row(k)));
            check({tag, ":last"}, 64'(out_last), 64'(k == N - 1));
            if (out_ready) k++;
            step();
            cyc++;
        end
        check({tag, ":xfers"}, 64'(k), 64'(N));
        if (exp_cycles > 0) check({tag, ":cycles"}, 64'(cyc), 64'(exp_cycles));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, ":end_ovalid"}, 64'(out_valid), 64'd0);
        check({tag, ":end_iready"}, 64'(in_ready), 64'd1);
        check({tag, ":end_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        abort     = 1'b0;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_row    = '0;
        out_ready = 1'b0;
        mode_ref  = 1'b0;

        // Reset values
        step();
        step();
        check("rst:iready", 64'(in_ready), 64'd1);
        check("rst:ovalid", 64'(out_valid), 64'd0);
        check("rst:last", 64'(out_last), 64'd0);
        check("rst:busy", 64'(busy), 64'd0);
        check("rst:row", 64'(out_row), 64'd0);
        rst_n = 1'b1;
        step();

        // Transpose of 10*r+c with out_ready held high: N-cycle drain
        fill_pattern();
        load("tp", 1'b0, 1'b0, N);
        drain("tp", 1'b0, N);

        // Pass-through, mode flipped after row 0
        load("pt", 1'b1, 1'b0, N);
        drain("pt", 1'b0, N);

        // Extreme values, bit-exact
        fill_pattern();
        mat[0][4] = 8'h80;
        mat[4][0] = 8'h7f;
        load("ext", 1'b0, 1'b0, N);
        drain("ext", 1'b0, N);

        // Random matrices, modes, input gaps and backpressure
        for (int i = 0; i < 6; i++) begin
            fill_random();
            load($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'b1, N);
            drain($sformatf("rnd%0d", i), 1'b1, 0);
        end

        // Abort while idle with a row offered: row dropped
        fill_random();
        abort    = 1'b1;
        in_valid = 1'b1;
        in_row   = pack_row(0);
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_idle:busy", 64'(busy), 64'd0);

        // Abort after 3 rows, then a fresh matrix
        load("ab3", 1'b1, 1'b0, 3);
        check("ab3:busy_pre", 64'(busy), 64'd1);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_row   = pack_row(3);
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("ab3:busy", 64'(busy), 64'd0);
        check("ab3:iready", 64'(in_ready), 64'd1);
        check("ab3:ovalid", 64'(out_valid), 64'd0);
        fill_random();
        load("ab3new", 1'b0, 1'b0, N);
        drain("ab3new", 1'b0, N);

        // Abort mid-drain with out_ready high
        fill_random();
        load("abd", 1'b0, 1'b0, N);
        out_ready = 1'b1;
        step();
        abort = 1'b1;
        step();
        abort     = 1'b0;
        out_ready = 1'b0;
        check("abd:ovalid", 64'(out_valid), 64'd0);
        check("abd:busy", 64'(busy), 64'd0);
        fill_random();
        load("abdnew", 1'b1, 1'b0, N);
        drain("abdnew", 1'b1, 0);

        // Reset after two output transfers
        fill_random();
        load("rsd", 1'b0, 1'b0, N);
        out_ready = 1'b1;
        step();
        step();
        check("rsd:row2", 64'(out_row), 64'(exp_row(2)));
        rst_n = 1'b0;
        #1;
        check("rsd:ovalid", 64'(out_valid), 64'd0);
        check("rsd:iready", 64'(in_ready), 64'd1);
        check("rsd:busy", 64'(busy), 64'd0);
        check("rsd:row", 64'(out_row), 64'd0);
        check("rsd:last", 64'(out_last), 64'd0);
        out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("rsd:post_ovalid", 64'(out_valid), 64'd0);
        fill_random();
        load("rsdnew", 1'b0, 1'b0, N);
        drain("rsdnew", 1'b0, N);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mpu_stream_transpose.md
MPU_STREAM_TRANSPOSE -- requirements
Module: mpu_stream_transpose

Interface
REQ-001 Parameter N, default 5: matrix dimension (N x N), legal range 2..8.
REQ-002 Parameter W, default 8: element width in bits, signed two's complement.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 abort  input  1  synchronous abort; discards the matrix in progress.
REQ-006 mode  input  1  0 = transpose, 1 = pass-through; sampled with the first row of each matrix.
REQ-007 in_valid  input  1  in_row carries a valid row.
REQ-008 in_ready  output  1  block accepts a row this cycle.
REQ-009 in_row  input  N*W  input row r; element c at bits [W*c +: W].
REQ-010 out_valid  output  1  out_row carries a valid row.
REQ-011 out_ready  input  1  downstream accepts out_row this cycle.
REQ-012 out_row  output  N*W  output row; element c at bits [W*c +: W].
REQ-013 out_last  output  1  high with the final (N-th) output row of a matrix.
REQ-014 busy  output  1  high whenever a matrix is partially loaded or draining.

Function
REQ-015 Input transfer occurs on a clk edge with in_valid && in_ready; output transfer on a clk edge with out_valid && out_ready.
REQ-016 Internal storage: one N x N x W buffer, a row counter (0..N-1) and a state register.
REQ-017 States: LOAD, DRAIN; reset state LOAD.
REQ-018 LOAD: in_ready = 1, out_valid = 0; each input transfer writes in_row into buffer row cnt, then increments cnt.
REQ-019 First input transfer of a matrix (cnt = 0) latches mode into the matrix's mode register; mode changes after that are ignored until the next matrix.
REQ-020 Input transfer at cnt = N-1: cnt -> 0, state -> DRAIN; out_valid is high on the following cycle (latency: 1 cycle from last input row to first output row).
REQ-021 DRAIN: in_ready = 0, out_valid = 1; in_valid is ignored.
REQ-022 DRAIN, transpose mode: out_row element c = buffer[c][cnt] (output row k = input column k).
REQ-023 DRAIN, pass-through mode: out_row element c = buffer[cnt][c].
REQ-024 out_last = 1 in DRAIN when cnt = N-1, else 0.
REQ-025 Output transfer increments cnt; at cnt = N-1 it returns cnt -> 0, state -> LOAD, so in_ready is high the next cycle.
REQ-026 With out_ready low, out_row, out_last and out_valid hold stable; no element is skipped or repeated.
REQ-027 busy = (state = DRAIN) or (state = LOAD and cnt != 0).
REQ-028 Elements are copied bit-exact; no sign extension, rounding or arithmetic.
REQ-029 abort high at a clk edge: state -> LOAD, cnt -> 0; any input/output transfer in that cycle is discarded; buffer contents need not be cleared.
REQ-030 abort has priority over all transfers; abort in LOAD with cnt = 0 has no effect.
REQ-031 Throughput: one matrix per 2N cycles with in_valid and out_ready held high; load and drain do not overlap.
REQ-032 out_row is a function of registered state only; in_ready does not depend combinationally on out_ready or in_valid.

Reset
REQ-033 rst_n low asynchronously forces state = LOAD, cnt = 0, matrix mode = 0.
REQ-034 Output values during and after reset: in_ready = 1, out_valid = 0, out_last = 0, busy = 0, out_row = 0 (buffer cleared).
REQ-035 Reset mid-load or mid-drain discards the matrix; no partial output follows reset release.

Verification
REQ-036 N=5, W=8, mode=0, in_row r element c = 10*r+c, out_ready=1 -> output row k element c = 10*c+k; out_last only on the 5th row; first out_valid 1 cycle after 5th input.
REQ-037 Same stimulus, mode=1 -> output rows equal the input rows in order; mode toggled to 0 after the first row has no effect.
REQ-038 Elements -128 and 127 at (0,4) and (4,0), mode=0 -> -128 appears at output (4,0), 127 at (0,4), bit-exact.
REQ-039 Random out_ready (50%) during drain -> out_row stable while out_valid && !out_ready; exactly 5 transfers; in_ready stays 0 until the 5th transfer.
REQ-040 abort after 3 input rows, then a full new matrix -> output equals transpose of the new matrix only; busy 0 the cycle after abort.
REQ-041 rst_n low for 1 cycle after 2 output transfers -> out_valid 0, in_ready 1, busy 0 immediately; next matrix processes correctly.
